zoom_hdmi_pixel_out: RTL and testbench

- Downstream consumer of the zoom-to-HDMI pixel FIFO.
- Generates HDMI/DVI video timing (hsync, vsync, de) in the pixel clock domain.
- Pops one 16-bit pixel from the FIFO read port per active-video cycle and presents aligned pixel data and sync signals to the HDMI encoder.
- Handles FIFO underflow by substituting black pixels and counting the events.

---
 rtl/zoom_hdmi_pixel_out.sv | 163 ++++++++++++++++
 tb/tb_zoom_hdmi_pixel_out.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/zoom_hdmi_pixel_out.sv
// zoom_hdmi_pixel_out
// Reads pixels from the zoom-to-HDMI FIFO and produces HDMI/DVI video timing
// in the pixel clock domain. It pops one pixel per active-video cycle and sends
// a black pixel whenever the FIFO is empty. Underflowed pixels are counted.
//
// Ports
//   clk, rst_n          pixel clock, synchronous active-low reset
//   enable              run request, sampled at frame boundaries
//   ufl_clr             clears ufl_flag / ufl_cnt (wins over a same-cycle event)
//   fifo_rd_data        FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_empty       FIFO empty
//   fifo_almost_empty   FIFO almost empty (gates the start of a frame)
//   fifo_rd_en          FIFO pop strobe (combinational from registered state)
//   vid_de/hs/vs/data   video outputs, 2 clocks after the counter position
//   frame_start         pulse aligned with the first active pixel of a frame
//   ufl_flag, ufl_cnt   sticky underflow flag, saturating underflow count
module zoom_hdmi_pixel_out #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BP       = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FP       = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 20,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  ufl_clr,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_almost_empty,
  output logic                  fifo_rd_en,
  output logic                  vid_de,
  output logic                  vid_hs,
  output logic                  vid_vs,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  frame_start,
  output logic                  ufl_flag,
  output logic [15:0]           ufl_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic [HW-1:0] r_h_cnt, w_h_nxt;
  logic [VW-1:0] r_v_cnt, w_v_nxt;

  logic w_run, w_h_last, w_v_last;
  logic w_active_raw, w_hs_raw, w_vs_raw, w_first, w_ufl_evt;

  logic r_s1_de, r_s1_hs, r_s1_vs, r_s1_first, r_s1_rd;

  // Raw timing decode from the counter position
  assign w_run        = (r_state == S_RUN);
  assign w_h_last     = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last     = (r_v_cnt == VW'(V_TOTAL - 1));
  assign w_active_raw = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs_raw     = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                        (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_raw     = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                        (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign w_first      = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);

  // Gated by rst_n so that a reset asserted mid-frame pops nothing more
  assign fifo_rd_en   = rst_n && w_run && w_active_raw && !fifo_rd_empty;
  assign w_ufl_evt    = w_run && w_active_raw && fifo_rd_empty;

  // Next state and counter update; counters sit at 0 outside RUN
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = '0;
    w_v_nxt     = '0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!enable)                 w_state_nxt = S_IDLE;
        else if (!fifo_almost_empty) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_h_last) begin
          if (w_v_last) begin
            if (!enable) w_state_nxt = S_IDLE;
          end else begin
            w_v_nxt = r_v_cnt + VW'(1);
          end
        end else begin
          w_h_nxt = r_h_cnt + HW'(1);
          w_v_nxt = r_v_cnt;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and position registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
    end
  end

  // Two-stage output pipeline; stage 2 lines up with the FIFO read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_de     <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_rd     <= 1'b0;
      vid_de      <= 1'b0;
      vid_hs      <= ~HS_POL;
      vid_vs      <= ~VS_POL;
      vid_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      r_s1_de     <= w_run && w_active_raw;
      r_s1_hs     <= w_run && w_hs_raw;
      r_s1_vs     <= w_run && w_vs_raw;
      r_s1_first  <= w_first;
      r_s1_rd     <= fifo_rd_en;
      vid_de      <= r_s1_de;
      vid_hs      <= r_s1_hs ~^ HS_POL;
      vid_vs      <= r_s1_vs ~^ VS_POL;
      vid_data    <= r_s1_rd ? fifo_rd_data : '0;
      frame_start <= r_s1_first;
    end
  end

  // Underflow bookkeeping; clear has priority over a coincident event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ufl_flag <= 1'b0;
      ufl_cnt  <= '0;
    end else if (ufl_clr) begin
      ufl_flag <= 1'b0;
      ufl_cnt  <= '0;
    end else if (w_ufl_evt) begin
      ufl_flag <= 1'b1;
      if (ufl_cnt != 16'hFFFF) ufl_cnt <= ufl_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_zoom_hdmi_pixel_out.sv
// Testbench for zoom_hdmi_pixel_out with a small video timing (14 x 7 clocks).
// The bench models the FIFO as a queue. A reference model follows the frame
// position and predicts every output from the timing rules.
module tb_zoom_hdmi_pixel_out;

  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam int AE_LEVEL = 5;

  logic        clk = 1'b0;
  logic        rst_n, enable, ufl_clr;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_empty, fifo_almost_empty;
  logic        fifo_rd_en, vid_de, vid_hs, vid_vs, frame_start, ufl_flag;
  logic [15:0] vid_data, ufl_cnt;

  always #5 clk = ~clk;

  zoom_hdmi_pixel_out #(
    .DATA_WIDTH(16), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ufl_clr(ufl_clr),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_almost_empty(fifo_almost_empty), .fifo_rd_en(fifo_rd_en),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_data(vid_data),
    .frame_start(frame_start), .ufl_flag(ufl_flag), .ufl_cnt(ufl_cnt)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [15:0] data;
  } vout_t;

  logic [15:0] q[$];
  int          fs_q[$];
  int          tests = 0, fails = 0;
  int          mode = 0;           // 0 idle, 1 waiting for FIFO level, 2 running
  int          pos = 0;            // clock index inside the current frame
  vout_t       m_s1 = '0, m_out = '0;
  logic        m_flag = 1'b0;
  int          m_cnt = 0;
  int          pops = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_flags();
    fifo_rd_empty     = (q.size() == 0);
    fifo_almost_empty = (q.size() < AE_LEVEL);
  endtask

  // One clock: predict, check the pop strobe, advance, check registered outputs
  task automatic tick();
    logic  run, act, exp_rd, act_rd, ev;
    vout_t t;
    int    hp, vp;
    #1;
    run    = (mode == 2);
    hp     = pos % HT;
    vp     = pos / HT;
    act    = run && (hp < HA) && (vp < VA);
    exp_rd = rst_n && act && (q.size() > 0);
    ev     = rst_n && act && (q.size() == 0);
    chk("rd_en", fifo_rd_en, exp_rd);
    act_rd = fifo_rd_en;
    t      = '0;
    t.de   = act;
    t.hs   = run && (hp >= HA + HFP) && (hp < HA + HFP + HSY);
    t.vs   = run && (vp == VA + VFP);
    t.fs   = run && (pos == 0);
    t.data = exp_rd ? q[0] : 16'h0;
    if (!rst_n) begin
      mode = 0; pos = 0; m_s1 = '0; m_out = '0; m_flag = 1'b0; m_cnt = 0;
    end else begin
      m_out = m_s1;
      m_s1  = t;
      if (ufl_clr) begin
        m_flag = 1'b0; m_cnt = 0;
      end else if (ev) begin
        m_flag = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
      case (mode)
        0: if (enable) mode = 1;
        1: if (!enable) mode = 0;
           else if (!fifo_almost_empty) begin mode = 2; pos = 0; end
        default: if (pos == FT - 1) begin
                   pos = 0;
                   if (!enable) mode = 0;
                 end else pos++;
      endcase
    end
    @(posedge clk);
    #1;
    if (act_rd && q.size() > 0) begin
      fifo_rd_data = q.pop_front();
      pops++;
    end
    upd_flags();
    @(negedge clk);
    chk("vid_de", vid_de, m_out.de);
    chk("vid_hs", vid_hs, m_out.hs);
    chk("vid_vs", vid_vs, m_out.vs);
    chk("frame_start", frame_start, m_out.fs);
    chk("vid_data", vid_data, m_out.data);
    chk("ufl_flag", ufl_flag, m_flag);
    chk("ufl_cnt", ufl_cnt, m_cnt);
    if (frame_start === 1'b1) fs_q.push_back(cyc);
    cyc++;
  endtask

  int p0, e0, occ;

  initial begin
    rst_n = 1'b0; enable = 1'b1; ufl_clr = 1'b0; fifo_rd_data = 16'h0;
    upd_flags();
    @(negedge clk);

    // Reset held with enable high
    repeat (5) tick();
    chk("s1_vid_hs_idle", vid_hs, 1'b0);
    chk("s1_vid_vs_idle", vid_vs, 1'b0);
    chk("s1_ufl_cnt", ufl_cnt, 16'd0);
    rst_n = 1'b1;

    // Empty FIFO keeps the block waiting
    repeat (6) tick();
    chk("s2_no_pop", pops, 0);

    // 16 words lift almost_empty; the rest of the 0..63 ramp follows
    for (int i = 0; i < 16; i++) q.push_back(16'(i));
    upd_flags();
    tick();
    for (int i = 16; i < 64; i++) q.push_back(16'(i));
    upd_flags();
    #1 chk("s2_first_pop", fifo_rd_en, 1'b1);
    e0 = cyc;
    p0 = pops;
    fs_q.delete();

    // Full frame, then a second frame with enable dropped partway through
    repeat (FT) tick();
    chk("s3_pops_frame1", pops - p0, 32);
    chk("s2_fs_latency", (fs_q.size() > 0) ? fs_q[0] - e0 : -1, 1);
    repeat (40) tick();
    enable = 1'b0;
    repeat (FT - 40) tick();
    chk("s5_pops_frame2", pops - p0, 64);
    repeat (20) tick();
    chk("s3_fs_gap", (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1, FT);
    chk("s5_no_fs_frame3", fs_q.size(), 2);
    chk("s5_no_more_pops", pops - p0, 64);
    chk("s5_fifo_drained", q.size(), 0);

    // Underflow: 5 random pixels then black for the rest of the frame
    for (int i = 0; i < 5; i++) q.push_back(16'($urandom));
    upd_flags();
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    repeat (FT + 12) tick();
    chk("s4_ufl_flag", ufl_flag, 1'b1);
    chk("s4_ufl_cnt", ufl_cnt, 16'd27);
    ufl_clr = 1'b1;
    tick();
    ufl_clr = 1'b0;
    chk("s4_ufl_cnt_clr", ufl_cnt, 16'd0);
    chk("s4_ufl_flag_clr", ufl_flag, 1'b0);

    // Reset at line 2, pixel 3 of a running frame
    for (int i = 0; i < 64; i++) q.push_back(16'($urandom));
    upd_flags();
    enable = 1'b1;
    for (int i = 0; i < 400 && !(mode == 2 && pos == 2 * HT + 3); i++) tick();
    chk("s6_reached_pos", (mode == 2 && pos == 2 * HT + 3), 1'b1);
    rst_n = 1'b0;
    occ = q.size();
    tick();
    chk("s6_occupancy", q.size(), occ);
    chk("s6_vid_de", vid_de, 1'b0);
    chk("s6_vid_data", vid_data, 16'h0);
    repeat (2) tick();
    chk("s6_occupancy_held", q.size(), occ);
    rst_n = 1'b1;

    // Random soak: sporadic writes, enable toggles and clears
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) q.push_back(16'($urandom));
      enable  = ($urandom_range(0, 9) != 0);
      ufl_clr = ($urandom_range(0, 40) == 0);
      upd_flags();
      tick();
    end
    ufl_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
